// File: rtl/cpu_pkg.sv
// Shared datapath types for the 16-bit core.
// Word and register-address widths plus the hardwired zero index.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int REG_ZERO   = 0;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_if.sv
// Register-file access bundle: one write port, two read ports.
// master drives we/wa/wd/ra1/ra2; slave returns rd1/rd2.
interface regfile_if
  import cpu_pkg::*;
#(
  parameter int n = DATA_W,
  parameter int r = REG_ADDR_W
);

  logic         we;
  logic [r-1:0] wa;
  logic [n-1:0] wd;
  logic [r-1:0] ra1;
  logic [r-1:0] ra2;
  logic [n-1:0] rd1;
  logic [n-1:0] rd2;

  modport master (
    output we, wa, wd, ra1, ra2,
    input  rd1, rd2
  );

  modport slave (
    input  we, wa, wd, ra1, ra2,
    output rd1, rd2
  );

endinterface

// File: rtl/regfile.sv
// 2**r x n register file, r0 hardwired to zero, optional write bypass.
// Ports: clk, rst_n (async low), bus (regfile_if.slave).
module regfile
  import cpu_pkg::*;
#(
  parameter int n      = DATA_W,
  parameter int r      = REG_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  regfile_if.slave bus
);

  localparam int DEPTH = 2 ** r;

  logic [n-1:0] mem [DEPTH];
  logic         wr_ok;

  assign wr_ok = bus.we && (bus.wa != r'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  logic [r-1:0] ra [2];
  logic [n-1:0] rd [2];

  assign ra[0]   = bus.ra1;
  assign ra[1]   = bus.ra2;
  assign bus.rd1 = rd[0];
  assign bus.rd2 = rd[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit;
    logic zero;

    // wr_ok already excludes r0, so a hit never forwards into r0
    assign hit  = BYPASS && rst_n && wr_ok
                  && (ra[p] == bus.wa);
    assign zero = !rst_n || (ra[p] == r'(REG_ZERO));

    always_comb begin
      rd[p] = mem[ra[p]];
      if (zero) begin
        rd[p] = '0;
      end else if (hit) begin
        rd[p] = bus.wd;
      end
    end
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Multi-port general-purpose register file for the 16-bit datapath.
- Sits directly upstream of the operand-select 2:1 muxes: rd2 feeds the ALU-B select (register vs immediate), and rd1 feeds the ALU-A/branch-base path.
- Provides two combinational read ports and one clocked write port.
- Register 0 is hardwired to zero; write-to-read bypass is optional.

Parameters:
- n, 16, data width in bits (matches the downstream mux width)
- r, 4, register address width; 2**r registers (16 by default)
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to the read port; 0 = reads return stored contents only

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset; clears every register
- we  input  1  write enable, sampled on rising clk
- wa  input  r  write address
- wd  input  n  write data
- ra1  input  r  read address, port 1
- ra2  input  r  read address, port 2
- rd1  output  n  read data, port 1 (combinational)
- rd2  output  n  read data, port 2 (combinational)

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Storage: 2**r words of n bits.
- Reset:
  - rst_n falling clears all registers to 0 immediately, with no clock edge required.
  - While rst_n = 0: rd1 = rd2 = 0, writes are ignored, and bypass is suppressed.
- Write:
  - On rising clk with rst_n = 1, we = 1 and wa != 0: reg[wa] <= wd.
  - Write latency is 1 cycle; the value is visible in stored contents after the edge.
- Register 0:
  - Writes to address 0 are discarded.
  - Reading address 0 always returns 0 on both ports, regardless of bypass.
- Read:
  - rd1 = reg[ra1] and rd2 = reg[ra2], purely combinational with zero-cycle latency.
  - Both ports are independent and may read the same address.
- Bypass (BYPASS = 1):
  - If rst_n = 1, we = 1, wa != 0 and raX == wa, then rdX = wd in the same cycle, before the edge.
  - Applies to both ports at once when both match.
- BYPASS = 0: rdX shows the old value until after the edge.
- Simultaneous write and read to the same address on the clock edge: the new value is stored; the read result follows the bypass rule above.
- Reset released mid-cycle (rst_n rising between edges): the first write takes effect on the next rising clk.
- Reset asserted on the same edge as a write: reset wins and the register stays 0.
- we = 0: no state change; wa and wd are don't-care.
- Reads are defined for every address value; there is no out-of-range case (2**r entries are fully decoded).

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W = 16 and REG_ADDR_W = 4 constants
  - typedef logic [DATA_W-1:0] word_t
  - typedef logic [REG_ADDR_W-1:0] reg_addr_t
  - localparam REG_ZERO = 0
- No sub-module is needed. Read ports are generated by one generate loop over the two ports; the bypass compare is inline.
- The downstream mux2 instances consume rd1/rd2 unchanged.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles after writing 0xBEEF to r5 -> rd1 (ra1 = 5) = 0x0000 both during and after reset; a write with we = 1 during reset leaves r5 = 0.
- Basic write/read: write r3 = 0x1234, r7 = 0xA5A5 on consecutive edges, then ra1 = 3, ra2 = 7 -> rd1 = 0x1234, rd2 = 0xA5A5.
- Zero register: we = 1, wa = 0, wd = 0xFFFF, clock once; ra1 = ra2 = 0 -> both 0x0000. With bypass enabled and wa = 0 in the same cycle, still 0x0000.
- Bypass: r4 = 0x0001 stored; drive we = 1, wa = 4, wd = 0x00FF with ra1 = ra2 = 4 before the edge -> BYPASS = 1: rd1 = rd2 = 0x00FF pre-edge; BYPASS = 0: 0x0001 pre-edge and 0x00FF post-edge.
- Async reset mid-cycle: assert rst_n low between clk edges after r9 = 0x7777 -> rd1 (ra1 = 9) drops to 0 without a clock edge. Release rst_n; the next-edge write of r9 = 0x0042 succeeds.
- Full sweep: write r1..r15 with value = address * 0x1111, then read all 16 addresses on both ports -> r0 = 0 and rk = k * 0x1111 (16-bit truncated); no aliasing between any pair.
